// File: rtl/inst_fetch_resp.sv
// Instruction-memory responder: accepts one fetch at a time, returns the stored word
// after LATENCY cycles, and flags misaligned or out-of-range fetch addresses.
module inst_fetch_resp #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h00400000,
    parameter int          LATENCY     = 2,
    parameter int          IW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_inst,
    output logic [31:0]   rsp_addr,
    output logic [1:0]    rsp_err,
    input  logic          load_en,
    input  logic [IW-1:0] load_index,
    input  logic [31:0]   load_data,
    output logic [15:0]   fetch_count
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic [31:0] decode_addr;
    logic [31:0] idx;
    logic        misaligned;
    logic        out_of_range;
    logic [1:0]  err_code;

    assign accept     = (state == IDLE) && req_valid;
    assign enter_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (wait_cnt == 4'd1));

    // With LATENCY=1 the response is captured on the accept edge, so decode the live address.
    assign decode_addr  = (state == IDLE) ? req_addr : addr_q;
    assign idx          = (decode_addr - BASE_ADDR) >> 2;
    assign misaligned   = |decode_addr[1:0];
    assign out_of_range = (decode_addr < BASE_ADDR) || (idx >= 32'(DEPTH_WORDS));
    assign err_code     = misaligned ? 2'b01 : (out_of_range ? 2'b10 : 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req_valid) next_state = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (wait_cnt == 4'd1) next_state = RESP;
            RESP: if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = !reset && (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= 4'd0;
            addr_q      <= 32'h0;
            rsp_inst    <= 32'h0;
            rsp_addr    <= 32'h0;
            rsp_err     <= 2'b00;
            fetch_count <= 16'h0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                wait_cnt <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            // Store read uses the pre-edge contents, so a same-edge load is not visible here.
            if (enter_resp) begin
                rsp_addr <= decode_addr;
                rsp_err  <= err_code;
                rsp_inst <= (err_code != 2'b00) ? 32'h0 : mem[idx[IW-1:0]];
            end
            if ((state == RESP) && rsp_ready) begin
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end

    // Load port is deliberately independent of reset so boot contents survive it.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_index] <= load_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: three instances (LATENCY 2, 4, 1) driven with directed
// vectors and hand-written multi-cycle sequences.
module tb_inst_fetch_resp;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset       [N];
    logic        req_valid   [N];
    logic        req_ready   [N];
    logic [31:0] req_addr    [N];
    logic        rsp_valid   [N];
    logic        rsp_ready   [N];
    logic [31:0] rsp_inst    [N];
    logic [31:0] rsp_addr    [N];
    logic [1:0]  rsp_err     [N];
    logic        load_en     [N];
    logic [7:0]  load_index  [N];
    logic [31:0] load_data   [N];
    logic [15:0] fetch_count [N];

    logic [15:0] exp_count [N];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
        inst_fetch_resp #(.LATENCY(LAT)) u_dut (
            .clk         (clk),
            .reset       (reset[g]),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_addr    (req_addr[g]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_ready   (rsp_ready[g]),
            .rsp_inst    (rsp_inst[g]),
            .rsp_addr    (rsp_addr[g]),
            .rsp_err     (rsp_err[g]),
            .load_en     (load_en[g]),
            .load_index  (load_index[g]),
            .load_data   (load_data[g]),
            .fetch_count (fetch_count[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_word(input int d, input logic [7:0] idx, input logic [31:0] data);
        load_en[d]    = 1'b1;
        load_index[d] = idx;
        load_data[d]  = data;
        @(negedge clk);
        load_en[d]    = 1'b0;
    endtask

    // Presents a request for one cycle; returns at the negedge after the accept edge.
    task automatic applyStimulus(input int d, input logic [31:0] addr);
        checkOutput("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_resp(input int d, output int cycles);
        cycles = 1;
        while (!rsp_valid[d] && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic handshake(input int d);
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        exp_count[d] = exp_count[d] + 16'd1;
        checkOutput("rsp_valid_cleared", 32'(rsp_valid[d]), 32'd0);
        checkOutput("req_ready_after", 32'(req_ready[d]), 32'd1);
        checkOutput("fetch_count", 32'(fetch_count[d]), 32'(exp_count[d]));
    endtask

    task automatic run_fetch(input int d, input logic [31:0] addr,
                             input logic [31:0] exp_inst, input logic [1:0] exp_err);
        int cyc;
        applyStimulus(d, addr);
        wait_resp(d, cyc);
        checkOutput("latency", 32'(cyc), 32'(lat_of(d)));
        checkOutput("rsp_valid", 32'(rsp_valid[d]), 32'd1);
        checkOutput("rsp_inst", rsp_inst[d], exp_inst);
        checkOutput("rsp_addr", rsp_addr[d], addr);
        checkOutput("rsp_err", 32'(rsp_err[d]), 32'(exp_err));
        handshake(d);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;

        vecs[0] = '{32'h00400020, 32'h2408000A, 2'b00};
        vecs[1] = '{32'h00400022, 32'h00000000, 2'b01};
        vecs[2] = '{32'h003FFFFC, 32'h00000000, 2'b10};
        vecs[3] = '{32'h00400400, 32'h00000000, 2'b10};
        vecs[4] = '{32'h00400402, 32'h00000000, 2'b01};
        vecs[5] = '{32'h00400000, 32'h11111111, 2'b00};
        vecs[6] = '{32'h004003FC, 32'hDEADBEEF, 2'b00};
        vecs[7] = '{32'h00000001, 32'h00000000, 2'b01};
        vecs[8] = '{32'hFFFFFFFC, 32'h00000000, 2'b10};

        for (int d = 0; d < N; d++) begin
            reset[d]      = 1'b1;
            req_valid[d]  = 1'b0;
            req_addr[d]   = 32'h0;
            rsp_ready[d]  = 1'b0;
            load_en[d]    = 1'b0;
            load_index[d] = 8'h0;
            load_data[d]  = 32'h0;
            exp_count[d]  = 16'h0;
        end

        repeat (2) @(negedge clk);
        for (int d = 0; d < N; d++) begin
            checkOutput("req_ready_in_reset", 32'(req_ready[d]), 32'd0);
            reset[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            checkOutput("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            checkOutput("reset_rsp_inst", rsp_inst[d], 32'h0);
            checkOutput("reset_rsp_addr", rsp_addr[d], 32'h0);
            checkOutput("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
            checkOutput("reset_fetch_count", 32'(fetch_count[d]), 32'd0);
            checkOutput("reset_req_ready", 32'(req_ready[d]), 32'd1);
        end

        // Directed vectors on the LATENCY=2 instance.
        load_word(0, 8'd8,   32'h2408000A);
        load_word(0, 8'd0,   32'h11111111);
        load_word(0, 8'd255, 32'hDEADBEEF);
        load_word(0, 8'd3,   32'hCAFEF00D);
        for (int i = 0; i < 9; i++) begin
            run_fetch(0, vecs[i].addr, vecs[i].inst, vecs[i].err);
        end

        $display("[TB] backpressure sequence");
        applyStimulus(0, 32'h0040000C);
        wait_resp(0, cyc);
        checkOutput("bp_latency", 32'(cyc), 32'd2);
        for (int i = 0; i < 5; i++) begin
            req_valid[0] = 1'b1;
            req_addr[0]  = 32'h00400100 + 32'(i * 4);
            @(negedge clk);
            checkOutput("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            checkOutput("bp_rsp_inst", rsp_inst[0], 32'hCAFEF00D);
            checkOutput("bp_rsp_addr", rsp_addr[0], 32'h0040000C);
            checkOutput("bp_rsp_err", 32'(rsp_err[0]), 32'd0);
            checkOutput("bp_req_ready", 32'(req_ready[0]), 32'd0);
        end
        req_valid[0] = 1'b0;
        handshake(0);
        @(negedge clk);
        checkOutput("bp_single_handshake", 32'(fetch_count[0]), 32'(exp_count[0]));
        checkOutput("bp_idle_no_rsp", 32'(rsp_valid[0]), 32'd0);

        $display("[TB] load collision sequence");
        applyStimulus(0, 32'h00400020);
        load_en[0]    = 1'b1;
        load_index[0] = 8'd8;
        load_data[0]  = 32'hFFFFFFFF;
        @(negedge clk);
        load_en[0]    = 1'b0;
        checkOutput("col_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        checkOutput("col_old_word", rsp_inst[0], 32'h2408000A);
        handshake(0);
        run_fetch(0, 32'h00400020, 32'hFFFFFFFF, 2'b00);

        $display("[TB] reset during WAIT sequence");
        load_word(1, 8'd8, 32'h2408000A);
        applyStimulus(1, 32'h00400020);
        reset[1] = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready_low", 32'(req_ready[1]), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        reset[1] = 1'b0;
        @(negedge clk);
        checkOutput("rst_req_ready_back", 32'(req_ready[1]), 32'd1);
        checkOutput("rst_fetch_count", 32'(fetch_count[1]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("rst_no_rsp", 32'(rsp_valid[1]), 32'd0);
        end
        run_fetch(1, 32'h00400020, 32'h2408000A, 2'b00);

        $display("[TB] counter wrap sequence");
        load_word(2, 8'd1, 32'h0000ABCD);
        run_fetch(2, 32'h00400004, 32'h0000ABCD, 2'b00);
        force g_dut[2].u_dut.fetch_count = 16'hFFFF;
        #1;
        release g_dut[2].u_dut.fetch_count;
        @(negedge clk);
        exp_count[2] = 16'hFFFF;
        checkOutput("preset_count", 32'(fetch_count[2]), 32'h0000FFFF);
        run_fetch(2, 32'h00400004, 32'h0000ABCD, 2'b00);
        run_fetch(2, 32'h00400400, 32'h00000000, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
